// File: rtl/alu_sel_pkg.sv
// Shared types and constants for the ALU result selector: skid-buffer state
// encoding, error-counter ceiling and the default channel map.
package alu_sel_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } sel_state_t;

    localparam logic [7:0] ERR_CNT_MAX = 8'd255;

    localparam int CH_ADD    = 0;
    localparam int CH_SUB    = 1;
    localparam int CH_X2     = 2;
    localparam int CH_D2     = 3;
    localparam int CH_AND    = 4;
    localparam int CH_OR     = 5;
    localparam int CH_XOR    = 6;
    localparam int CH_NOT    = 7;
    localparam int CH_EQ     = 8;
    localparam int CH_GT     = 9;
    localparam int CH_LT     = 10;
    localparam int CH_MAX    = 11;
    localparam int CH_KNIGHT = 12;

endpackage

// File: rtl/alu_sel_skid.sv
// Two-entry skid buffer (main + skid register). Both ready and valid are
// registered, so upstream never sees a combinational path from out_ready.
module alu_sel_skid
    import alu_sel_pkg::*;
#(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [PW-1:0] in_payload,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [PW-1:0] out_payload,
    output logic          out_valid,
    input  logic          out_ready,
    output sel_state_t    state
);

    sel_state_t      r_state;
    logic [PW-1:0]   r_main;
    logic [PW-1:0]   r_skid;
    logic            r_in_ready;
    logic            r_out_valid;
    logic            w_in_xfer;
    logic            w_out_xfer;

    // Handshake: a beat moves on a rising edge where valid and ready are both high.
    assign w_in_xfer  = in_valid && r_in_ready;
    assign w_out_xfer = r_out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_main      <= '0;
            r_skid      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        r_main      <= in_payload;
                        r_state     <= ST_ONE;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_in_xfer && !w_out_xfer) begin
                        r_skid     <= in_payload;
                        r_state    <= ST_FULL;
                        r_in_ready <= 1'b0;
                    end else if (!w_in_xfer && w_out_xfer) begin
                        r_state     <= ST_EMPTY;
                        r_out_valid <= 1'b0;
                    end else if (w_in_xfer && w_out_xfer) begin
                        r_main <= in_payload;
                    end
                end
                ST_FULL: begin
                    if (w_out_xfer) begin
                        r_main     <= r_skid;
                        r_state    <= ST_ONE;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_payload = r_main;
    assign state       = r_state;

endmodule

// File: rtl/alu_result_sel.sv
// Registered N-way ALU result selector with illegal-select detection and a
// saturating error counter. Define ALU_RESULT_SEL_FLAGS_EN for zero/neg flags.
module alu_result_sel
    import alu_sel_pkg::*;
#(
    parameter int N  = 13,
    parameter int W  = 8,
    parameter int SW = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N*W-1:0] ch_data,
    input  logic [SW-1:0]  in_sel,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_sel,
    output logic           out_err,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [7:0]     err_cnt,
`ifdef ALU_RESULT_SEL_FLAGS_EN
    output logic           out_zero,
    output logic           out_neg,
`endif
    output sel_state_t     dbg_state
);

`ifdef ALU_RESULT_SEL_FLAGS_EN
    localparam int FW = 2;
`else
    localparam int FW = 0;
`endif
    localparam int PW = W + SW + 1 + FW;

    logic [W-1:0]  w_data;
    logic          w_err;
    logic [PW-1:0] w_in_payload;
    logic [PW-1:0] w_out_payload;
    logic          w_in_ready;
    logic [7:0]    r_err_cnt;

    // Illegal selects match no channel, so the captured data stays zero.
    always_comb begin
        w_data = '0;
        for (int k = 0; k < N; k++) begin
            if (in_sel == SW'(k)) w_data = ch_data[k*W +: W];
        end
        w_err = (int'(in_sel) >= N);
    end

`ifdef ALU_RESULT_SEL_FLAGS_EN
    assign w_in_payload = {w_err, in_sel, w_data,
                           (w_data == '0) && !w_err, w_data[W-1] && !w_err};
`else
    assign w_in_payload = {w_err, in_sel, w_data};
`endif

    alu_sel_skid #(.PW(PW)) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_payload  (w_in_payload),
        .in_valid    (in_valid),
        .in_ready    (w_in_ready),
        .out_payload (w_out_payload),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .state       (dbg_state)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (in_valid && w_in_ready && w_err && (r_err_cnt != ERR_CNT_MAX)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign in_ready = w_in_ready;
    assign err_cnt  = r_err_cnt;
    assign out_data = w_out_payload[FW +: W];
    assign out_sel  = w_out_payload[FW+W +: SW];
    assign out_err  = w_out_payload[PW-1];
`ifdef ALU_RESULT_SEL_FLAGS_EN
    assign out_zero = w_out_payload[1];
    assign out_neg  = w_out_payload[0];
`endif

endmodule

// File: tb/tb_alu_result_sel.sv
// Directed self-checking bench for alu_result_sel: reset, streaming,
// backpressure, illegal selects, error saturation, mid-flight reset, flags.
module tb_alu_result_sel;
  import alu_sel_pkg::*;

  localparam int N  = 13;
  localparam int W  = 8;
  localparam int SW = 4;

  logic           clk;
  logic           rst_n;
  logic [N*W-1:0] ch_data;
  logic [SW-1:0]  in_sel;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_sel;
  logic           out_err;
  logic           out_valid;
  logic           out_ready;
  logic [7:0]     err_cnt;
`ifdef ALU_RESULT_SEL_FLAGS_EN
  logic           out_zero;
  logic           out_neg;
`endif
  sel_state_t     dbg_state;

  int checks;
  int errors;
  int exp_err;
  logic [W-1:0] exp_q[$];

  alu_result_sel #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ch_data   (ch_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err_cnt   (err_cnt),
`ifdef ALU_RESULT_SEL_FLAGS_EN
    .out_zero  (out_zero),
    .out_neg   (out_neg),
`endif
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_slice(input int k, input logic [W-1:0] v);
    ch_data[k*W +: W] = v;
  endtask

  task automatic drive(input int sel, input logic [W-1:0] v);
    in_sel = SW'(sel);
    if (sel < N) set_slice(sel, v);
    in_valid = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; ch_data = '0; in_sel = '0;
    #12;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || err_cnt !== 8'd0 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL reset: valid=%b ready=%b err_cnt=%0d data=%h, want 0 1 0 00",
               out_valid, in_ready, err_cnt, out_data);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); drive(4, 8'h3C);
    @(negedge clk); in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h3C || out_sel !== 4'd4 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL first_beat: valid=%b data=%h sel=%0d err=%b, want 1 3c 4 0",
               out_valid, out_data, out_sel, out_err);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_after_first: valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_streaming;
    logic [W-1:0] exp;
    out_ready = 1'b1;
    for (int j = 0; j <= N; j++) begin
      @(negedge clk);
      if (j > 0) begin
        exp = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp) begin
          errors++;
          $display("FAIL stream_beat%0d: valid=%b data=%h, want 1 %h", j-1, out_valid, out_data, exp);
        end
      end
      if (j < N) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL stream_ready%0d: in_ready=%b, want 1", j, in_ready);
        end
        drive(j, W'(j + 'h10));
        exp_q.push_back(W'(j + 'h10));
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stream_end: valid=%b left=%0d, want 0 0", out_valid, exp_q.size());
    end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    @(negedge clk); drive(1, 8'hA1);
    @(negedge clk); drive(2, 8'hB2);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_data !== 8'hA1 || out_valid !== 1'b1 || dbg_state !== ST_FULL) begin
      errors++;
      $display("FAIL bp_full: ready=%b data=%h valid=%b state=%0d, want 0 a1 1 2",
               in_ready, out_data, out_valid, dbg_state);
    end
    // Illegal select offered while FULL must be ignored entirely.
    in_sel = 4'd13; ch_data = {N*W{1'b1}}; in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (err_cnt !== 8'(exp_err) || out_data !== 8'hA1 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL bp_hold: err_cnt=%0d data=%h err=%b, want %0d a1 0", err_cnt, out_data, out_err, exp_err);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hB2 || out_sel !== 4'd2 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_second: valid=%b data=%h sel=%0d ready=%b, want 1 b2 2 1",
               out_valid, out_data, out_sel, in_ready);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_illegal;
    out_ready = 1'b1; ch_data = {N*W{1'b1}};
    @(negedge clk); drive(13, 8'h00);
    @(negedge clk); drive(15, 8'h00);
    exp_err++;
    checks++;
    if (out_data !== 8'h00 || out_err !== 1'b1 || out_sel !== 4'd13 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL illegal13: data=%h err=%b sel=%0d valid=%b, want 00 1 13 1",
               out_data, out_err, out_sel, out_valid);
    end
    @(negedge clk); in_valid = 1'b0;
    exp_err++;
    checks++;
    if (out_data !== 8'h00 || out_err !== 1'b1 || out_sel !== 4'd15 || err_cnt !== 8'(exp_err)) begin
      errors++;
      $display("FAIL illegal15: data=%h err=%b sel=%0d err_cnt=%0d, want 00 1 15 %0d",
               out_data, out_err, out_sel, err_cnt, exp_err);
    end
  endtask

  task automatic test_err_saturate;
    out_ready = 1'b1;
    @(negedge clk); drive(14, 8'h00);
    repeat (300) @(negedge clk);
    in_valid = 1'b0;
    exp_err = (exp_err + 300 > 255) ? 255 : exp_err + 300;
    @(negedge clk); @(negedge clk);
    checks++;
    if (err_cnt !== 8'(exp_err)) begin
      errors++;
      $display("FAIL err_saturate: err_cnt=%0d, want %0d", err_cnt, exp_err);
    end
  endtask

  task automatic test_midflight_reset;
    out_ready = 1'b0;
    @(negedge clk); drive(5, 8'h55);
    @(negedge clk); drive(6, 8'h66);
    @(negedge clk); in_valid = 1'b0;
    checks++;
    if (dbg_state !== ST_FULL) begin
      errors++;
      $display("FAIL mid_full: state=%0d, want 2", dbg_state);
    end
    #2 rst_n = 1'b0;
    #1;
    exp_err = 0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || err_cnt !== 8'd0 || out_data !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset: valid=%b ready=%b err_cnt=%0d data=%h, want 0 1 0 00",
               out_valid, in_ready, err_cnt, out_data);
    end
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_ghost%0d: valid=%b data=%h, want valid 0", j, out_valid, out_data);
      end
    end
  endtask

`ifdef ALU_RESULT_SEL_FLAGS_EN
  task automatic test_flags;
    out_ready = 1'b0;
    @(negedge clk); drive(0, 8'h00);
    @(negedge clk); drive(1, 8'h80);
    checks++;
    if (out_zero !== 1'b1 || out_neg !== 1'b0) begin
      errors++;
      $display("FAIL flags_zero: zero=%b neg=%b, want 1 0", out_zero, out_neg);
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_zero !== 1'b0 || out_neg !== 1'b1 || out_data !== 8'h80) begin
      errors++;
      $display("FAIL flags_neg: zero=%b neg=%b data=%h, want 0 1 80", out_zero, out_neg, out_data);
    end
    ch_data = '0; drive(13, 8'h00);
    @(negedge clk); in_valid = 1'b0;
    exp_err++;
    checks++;
    if (out_zero !== 1'b0 || out_neg !== 1'b0 || out_err !== 1'b1) begin
      errors++;
      $display("FAIL flags_illegal: zero=%b neg=%b err=%b, want 0 0 1", out_zero, out_neg, out_err);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    checks = 0; errors = 0; exp_err = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_illegal();
    test_err_saturate();
    test_midflight_reset();
`ifdef ALU_RESULT_SEL_FLAGS_EN
    test_flags();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
